// File: rtl/metrics_div_arbiter_pkg.sv
// Shared fixed-point parameters and state encoding for the metrics datapath.
// The arithmetic blocks import this package so that the Q-format widths and the
// divider sequencer states are defined in one place.
//   FXP_WIDTH   : fixed-point word width (Q8.8)
//   FXP_FRAC    : number of fractional bits
//   QUO_MAX     : largest positive Q8.8 value, used as the saturation value
//   div_state_t : shared divider sequencer states
package complex_adaptive_kalman_params;

    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 8;
    localparam logic [FXP_WIDTH-1:0] QUO_MAX = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : complex_adaptive_kalman_params

// File: rtl/metrics_div_arbiter_if.sv
// Request/response bundle between the metrics requesters and the shared divider.
//   req_valid    : per-requester request valid
//   req_ready    : per-requester accept, one-hot or zero
//   req_dividend : flat bus, requester i at [i*DIVIDEND_W +: DIVIDEND_W]
//   req_divisor  : flat bus, requester i at [i*DIVISOR_W +: DIVISOR_W]
//   rsp_valid    : one-hot single-cycle response pulse
//   rsp_quotient : saturated Q8.8 quotient, held between pulses
//   rsp_div_zero : divisor was zero, held between pulses
//   busy         : divider is not idle
// master = requester side, slave = divider side.
interface metrics_div_if
    import complex_adaptive_kalman_params::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = FXP_WIDTH + 8,
    parameter int QUO_W      = FXP_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend;
    logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [QUO_W-1:0]              rsp_quotient;
    logic                          rsp_div_zero;
    logic                          busy;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, rsp_valid, rsp_quotient, rsp_div_zero, busy
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, rsp_valid, rsp_quotient, rsp_div_zero, busy
    );

endinterface : metrics_div_if

// File: rtl/metrics_rr_arbiter.sv
// Combinational round-robin arbiter shared by the shared-resource blocks.
// Grants the first requesting index at or after (last_grant_i + 1) mod NUM_REQ.
//   req_i        : request vector
//   last_grant_i : index granted most recently
//   enable_i     : when low no grant is issued
//   grant_o      : one-hot grant, or zero
module metrics_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        logic found_s;
        int   idx_s;
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = 0;
        if (enable_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_s = (int'(last_grant_i) + 1 + i) % NUM_REQ;
                if (!found_s && req_i[idx_s]) begin
                    grant_o[idx_s] = 1'b1;
                    found_s        = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant_o = '0;
        end
    end

endmodule : metrics_rr_arbiter

// File: rtl/metrics_div_arbiter.sv
// Round-robin sequencer for one shared iterative unsigned restoring divider.
// A granted request is divided MSB-first, one quotient bit per cycle, and the
// saturated quotient is returned as a one-cycle pulse to the requester.
// A zero divisor skips the iterations and answers on the next cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   div_if       : request/response bundle (slave side)
// Optional build macro METRICS_DIV_STATS_EN adds:
//   stat_div_zero_cnt_o : saturating count of divide-by-zero responses
//   stat_sat_cnt_o      : saturating count of saturated responses
module metrics_div_arbiter
    import complex_adaptive_kalman_params::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = FXP_WIDTH + 8,
    parameter int QUO_W      = FXP_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef METRICS_DIV_STATS_EN
    output logic [15:0] stat_div_zero_cnt_o,
    output logic [15:0] stat_sat_cnt_o,
`endif
    metrics_div_if.slave div_if
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [QUO_W-1:0]      SAT_VAL  = {1'b0, {(QUO_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] SAT_WIDE = {{(DIVIDEND_W-QUO_W){1'b0}}, SAT_VAL};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    div_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [DIVISOR_W:0]      rem_q, rem_d;
    logic [DIVIDEND_W-1:0]   quo_q, quo_d;
    logic [DIVISOR_W-1:0]    divisor_q, divisor_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [QUO_W-1:0]        rsp_quotient_q, rsp_quotient_d;
    logic                    rsp_div_zero_q, rsp_div_zero_d;
    logic                    busy_q, busy_d;

    logic [NUM_REQ-1:0]      grant_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [DIVIDEND_W-1:0]   sel_dividend_s;
    logic [DIVISOR_W-1:0]    sel_divisor_s;
    logic [DIVISOR_W+1:0]    rem_shift_s;
    logic [DIVISOR_W:0]      rem_diff_s;
    logic                    fits_s;
    logic [DIVISOR_W:0]      rem_step_s;
    logic [DIVIDEND_W-1:0]   quo_step_s;
    logic                    over_s;

    // Grants are only offered while idle.
    metrics_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i        (div_if.req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == IDLE),
        .grant_o      (grant_s)
    );

    // One-hot grant to index.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                win_idx_s = IDX_W'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    assign sel_dividend_s = div_if.req_dividend[win_idx_s*DIVIDEND_W +: DIVIDEND_W];
    assign sel_divisor_s  = div_if.req_divisor[win_idx_s*DIVISOR_W +: DIVISOR_W];

    // One restoring step: shift next dividend bit into the remainder, subtract
    // when it fits. The remainder stays below the divisor, so the difference
    // always fits in DIVISOR_W+1 bits.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[DIVIDEND_W-1]};
        fits_s      = (rem_shift_s >= {2'b00, divisor_q});
        rem_diff_s  = rem_shift_s[DIVISOR_W:0] - {1'b0, divisor_q};
        rem_step_s  = fits_s ? rem_diff_s : rem_shift_s[DIVISOR_W:0];
        quo_step_s  = {quo_q[DIVIDEND_W-2:0], fits_s};
        over_s      = (quo_step_s > SAT_WIDE);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        grant_idx_d    = grant_idx_q;
        last_grant_d   = last_grant_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        divisor_d      = divisor_q;
        rsp_valid_d    = '0;
        rsp_quotient_d = rsp_quotient_q;
        rsp_div_zero_d = rsp_div_zero_q;
        case (state_q)
            IDLE: begin
                if (|grant_s) begin
                    grant_idx_d  = win_idx_s;
                    last_grant_d = win_idx_s;
                    divisor_d    = sel_divisor_s;
                    quo_d        = sel_dividend_s;
                    rem_d        = '0;
                    cnt_d        = '0;
                    if (sel_divisor_s == '0) begin
                        // Answer immediately; the response lands with DONE.
                        state_d        = DONE;
                        rsp_valid_d    = grant_s;
                        rsp_quotient_d = SAT_VAL;
                        rsp_div_zero_d = 1'b1;
                    end else begin
                        state_d = ITER;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last step: register the response so it aligns with DONE.
                    state_d        = DONE;
                    rsp_valid_d    = NUM_REQ'(1) << grant_idx_q;
                    rsp_quotient_d = over_s ? SAT_VAL : quo_step_s[QUO_W-1:0];
                    rsp_div_zero_d = 1'b0;
                end else begin
                    state_d = ITER;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            grant_idx_q    <= '0;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            rem_q          <= '0;
            quo_q          <= '0;
            divisor_q      <= '0;
            rsp_valid_q    <= '0;
            rsp_quotient_q <= '0;
            rsp_div_zero_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            grant_idx_q    <= grant_idx_d;
            last_grant_q   <= last_grant_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            divisor_q      <= divisor_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_quotient_q <= rsp_quotient_d;
            rsp_div_zero_q <= rsp_div_zero_d;
            busy_q         <= busy_d;
        end
    end

    assign div_if.req_ready    = grant_s;
    assign div_if.rsp_valid    = rsp_valid_q;
    assign div_if.rsp_quotient = rsp_quotient_q;
    assign div_if.rsp_div_zero = rsp_div_zero_q;
    assign div_if.busy         = busy_q;

`ifdef METRICS_DIV_STATS_EN
    logic        sat_q, sat_d;
    logic [15:0] dz_cnt_q, dz_cnt_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Saturation flag travels with the response; counters bump in DONE.
    always_comb begin
        sat_d     = sat_q;
        dz_cnt_d  = dz_cnt_q;
        sat_cnt_d = sat_cnt_q;
        if ((state_q == ITER) && (cnt_q == CNT_LAST)) begin
            sat_d = over_s;
        end else if ((state_q == IDLE) && (|grant_s)) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
        if (state_q == DONE) begin
            if (rsp_div_zero_q && (dz_cnt_q != 16'hFFFF)) begin
                dz_cnt_d = dz_cnt_q + 16'd1;
            end else begin
                dz_cnt_d = dz_cnt_q;
            end
            if (sat_q && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end else begin
                sat_cnt_d = sat_cnt_q;
            end
        end else begin
            dz_cnt_d  = dz_cnt_q;
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q     <= 1'b0;
            dz_cnt_q  <= 16'd0;
            sat_cnt_q <= 16'd0;
        end else begin
            sat_q     <= sat_d;
            dz_cnt_q  <= dz_cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign stat_div_zero_cnt_o = dz_cnt_q;
    assign stat_sat_cnt_o      = sat_cnt_q;
`endif

endmodule : metrics_div_arbiter

// File: tb/tb_metrics_div_arbiter.sv
// Scoreboard bench for metrics_div_arbiter: drivers push expected responses,
// a monitor pops and compares on every rsp_valid pulse.
module tb_metrics_div_arbiter;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    typedef struct {
        logic [1:0]  mask;
        logic [15:0] q;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    metrics_div_if #(.NUM_REQ(2), .DIVIDEND_W(32), .DIVISOR_W(24), .QUO_W(16)) dif();

`ifdef METRICS_DIV_STATS_EN
    logic [15:0] stat_dz;
    logic [15:0] stat_sat;
`endif

    metrics_div_arbiter #(.NUM_REQ(2), .DIVIDEND_W(32), .DIVISOR_W(24), .QUO_W(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
`ifdef METRICS_DIV_STATS_EN
        .stat_div_zero_cnt_o (stat_dz),
        .stat_sat_cnt_o      (stat_sat),
`endif
        .div_if              (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant legality every cycle, scoreboard compare on each response.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 32'($countones(dif.req_ready) <= 1), 32'd1);
            check("ready_when_busy", 32'(dif.busy & (|dif.req_ready)), 32'd0);
            if (|dif.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(dif.rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_valid", 32'(dif.rsp_valid), 32'(mon_e.mask));
                    check("rsp_quotient", 32'(dif.rsp_quotient), 32'(mon_e.q));
                    check("rsp_div_zero", 32'(dif.rsp_div_zero), 32'(mon_e.z));
                    check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    // Present one request, wait for its grant, push the expected response.
    task automatic issue(input int r, input logic [31:0] dd, input logic [23:0] dv,
                         input logic [15:0] eq, input logic ez, input bit want, output int t);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        dif.req_dividend[r*32 +: 32] = dd;
        dif.req_divisor[r*24 +: 24]  = dv;
        dif.req_valid[r]             = 1'b1;
        #1;
        while (!dif.req_ready[r] && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!dif.req_ready[r]) begin
            check("grant_timeout", 32'd1, 32'd0);
            t = -1;
            dif.req_valid[r] = 1'b0;
        end else begin
            t      = cyc;
            e.mask = 2'b00;
            e.mask[r] = 1'b1;
            e.q    = eq;
            e.z    = ez;
            e.cyc  = t + ((dv == 24'd0) ? 1 : 33);
            if (want) sb.push_back(e);
            @(posedge clk);
            #1;
            dif.req_valid[r] = 1'b0;
        end
    endtask

    // Both requesters held; grants must alternate starting at req0, 34 cycles apart.
    task automatic both_held(input int n);
        int   granted;
        int   last_t;
        int   w;
        int   g;
        exp_t e;
        granted = 0;
        last_t  = 0;
        w       = 0;
        @(negedge clk);
        dif.req_dividend = {32'h0000_1000, 32'h0000_0900};
        dif.req_divisor  = {24'h00_0010, 24'h00_0003};
        dif.req_valid    = 2'b11;
        #1;
        while (granted < n && w < 500) begin
            if (|dif.req_ready) begin
                g = dif.req_ready[1] ? 1 : 0;
                check("rr_order", 32'(g), 32'(granted % 2));
                if (granted > 0) check("rr_spacing", 32'(cyc - last_t), 32'd34);
                e.mask = 2'b00;
                e.mask[g] = 1'b1;
                e.q    = (g == 0) ? 16'h0300 : 16'h0100;
                e.z    = 1'b0;
                e.cyc  = cyc + 33;
                sb.push_back(e);
                last_t = cyc;
                granted++;
            end
            if (granted < n) begin
                @(negedge clk);
                #1;
                w++;
            end
        end
        if (granted < n) check("rr_timeout", 32'(granted), 32'(n));
        @(posedge clk);
        #1;
        dif.req_valid = 2'b00;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        int          r;
        logic [31:0] dd;
        logic [23:0] dv;
        logic [15:0] q;
        logic        z;
    } vec_t;

    vec_t vecs[6] = '{
        '{0, 32'h00FF_0000, 24'h00_0001, 16'h7FFF, 1'b0},
        '{1, 32'h0001_2345, 24'h00_0100, 16'h0123, 1'b0},
        '{0, 32'hFFFF_FFFF, 24'hFF_FFFF, 16'h0100, 1'b0},
        '{1, 32'h0001_0000, 24'h00_0003, 16'h5555, 1'b0},
        '{0, 32'h0000_7FFF, 24'h00_0001, 16'h7FFF, 1'b0},
        '{1, 32'h0000_8000, 24'h00_0001, 16'h7FFF, 1'b0}
    };

    initial begin
        int t;
        cyc = 0;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        dif.req_valid    = 2'b00;
        dif.req_dividend = '0;
        dif.req_divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(dif.rsp_valid), 32'd0);
        check("rst_quotient", 32'(dif.rsp_quotient), 32'd0);
        check("rst_div_zero", 32'(dif.rsp_div_zero), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_no_ready", 32'(dif.req_ready), 32'd0);

        // Basic division with busy window check.
        issue(0, 32'h0000_0600, 24'h00_0002, 16'h0300, 1'b0, 1'b1, t);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            check("busy_high", 32'(dif.busy), 32'd1);
        end
        @(negedge clk);
        check("busy_low", 32'(dif.busy), 32'd0);
        check("quotient_hold", 32'(dif.rsp_quotient), 32'h0300);

        // Divide by zero answers on the next cycle.
        issue(1, 32'h0000_1234, 24'h00_0000, 16'h7FFF, 1'b1, 1'b1, t);
        drain();
        check("div_zero_hold", 32'(dif.rsp_div_zero), 32'd1);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].r, vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].z, 1'b1, t);
        end
        drain();

        // Request that withdraws while the divider is busy must leave no trace.
        issue(0, 32'h0000_0600, 24'h00_0003, 16'h0200, 1'b0, 1'b1, t);
        dif.req_divisor[24 +: 24] = 24'h00_0000;
        dif.req_valid[1] = 1'b1;
        repeat (5) @(negedge clk);
        dif.req_valid[1] = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // Reset in the middle of a req1 division: nothing comes back.
        issue(1, 32'h0000_5000, 24'h00_0005, 16'h1000, 1'b0, 1'b0, t);
        while (cyc < t + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(dif.busy), 32'd0);
        check("midrst_rsp", 32'(dif.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Priority back at req0 after reset; both held alternate.
        both_held(3);
        drain();

`ifdef METRICS_DIV_STATS_EN
        for (int i = 0; i < 3; i++) issue(i % 2, 32'h0000_0010, 24'h00_0000, 16'h7FFF, 1'b1, 1'b1, t);
        issue(0, 32'h00FF_0000, 24'h00_0001, 16'h7FFF, 1'b0, 1'b1, t);
        issue(1, 32'h0001_0000, 24'h00_0001, 16'h7FFF, 1'b0, 1'b1, t);
        drain();
        repeat (2) @(negedge clk);
        check("stat_div_zero_cnt", 32'(stat_dz), 32'd3);
        check("stat_sat_cnt", 32'(stat_sat), 32'd2);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_metrics_div_arbiter
